// File: rtl/sprite_oam_scan.sv
// Per-line OAM search: walks 40 entries (Y then X byte), keeps up to MAX_SEL covering sprites in OAM order.
// 81 scan cycles after start, one done cycle; no backpressure, the list is read through a combinational port.
module sprite_oam_scan #(
  parameter int SPRITES = 40,
  parameter int MAX_SEL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] v_cnt,
  input  logic       size16,
  output logic       oam_rd,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_di,
  output logic       busy,
  output logic       done,
  output logic [3:0] sel_count,
  output logic       overflow,
  input  logic [3:0] rd_index,
  output logic       rd_valid,
  output logic [7:0] rd_x,
  output logic [5:0] rd_id,
  output logic [3:0] rd_row
);

  localparam logic [6:0] C_LAST   = 7'(2 * SPRITES);
  localparam logic [3:0] SEL_MAX4 = 4'(MAX_SEL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [6:0] c;
  logic [7:0] line;
  logic       h16;
  logic [7:0] addr_q;
  logic       hit_q;
  logic [3:0] row_q;

  logic [7:0] addr_now;
  logic       issue;
  logic       y_cyc;
  logic       x_cyc;
  logic [7:0] row_calc;
  logic       row_hit;
  logic       wr_en;
  logic [5:0] entry;

  logic [7:0] x_mem   [MAX_SEL];
  logic [5:0] id_mem  [MAX_SEL];
  logic [3:0] row_mem [MAX_SEL];

  // ---------------- state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = SCAN;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        SCAN:    if (c == C_LAST) state_nx = FIN;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = 1'b0;
    oam_rd = 1'b0;
    done   = 1'b0;
    case (state)
      SCAN: begin
        busy   = 1'b1;
        oam_rd = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- scan datapath ----------------
  // Entry e sits at byte 4e; even c reads its Y, odd c its X.
  assign addr_now = {c[6:1], 1'b0, c[0]};
  assign issue    = (state == SCAN) && (c != C_LAST);
  assign oam_addr = issue ? addr_now : addr_q;

  // Data lags the address by one cycle: Y arrives on odd c, X on even c >= 2.
  assign y_cyc    = c[0];
  assign x_cyc    = !c[0] && (c != 7'd0);
  assign entry    = c[6:1] - 6'd1;
  assign row_calc = line + 8'd16 - oam_di;
  assign row_hit  = h16 ? (row_calc < 8'd16) : (row_calc < 8'd8);
  assign wr_en    = (state == SCAN) && !start && x_cyc && hit_q && (sel_count < SEL_MAX4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c         <= 7'd0;
      line      <= 8'd0;
      h16       <= 1'b0;
      addr_q    <= 8'd0;
      hit_q     <= 1'b0;
      row_q     <= 4'd0;
      sel_count <= 4'd0;
      overflow  <= 1'b0;
    end else if (start) begin
      c         <= 7'd0;
      line      <= v_cnt;
      h16       <= size16;
      hit_q     <= 1'b0;
      sel_count <= 4'd0;
      overflow  <= 1'b0;
    end else if (state == SCAN) begin
      if (issue) begin
        c      <= c + 7'd1;
        addr_q <= addr_now;
      end
      if (y_cyc) begin
        hit_q <= row_hit;
        row_q <= row_calc[3:0];
      end
      if (x_cyc && hit_q) begin
        if (sel_count < SEL_MAX4) begin
          sel_count <= sel_count + 4'd1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // List storage is never reset; rd_valid masks stale slots.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      x_mem[sel_count]   <= oam_di;
      id_mem[sel_count]  <= entry;
      row_mem[sel_count] <= row_q;
    end
  end

  // ---------------- read port ----------------
  assign rd_valid = rd_index < sel_count;

  always_comb begin
    rd_x   = 8'd0;
    rd_id  = 6'd0;
    rd_row = 4'd0;
    for (int i = 0; i < MAX_SEL; i++) begin
      if (rd_valid && (rd_index == 4'(i))) begin
        rd_x   = x_mem[i];
        rd_id  = id_mem[i];
        rd_row = row_mem[i];
      end
    end
  end

endmodule

// File: tb/tb_sprite_oam_scan.sv
// Scoreboarded bench for sprite_oam_scan: directed corner scans plus random OAM images against a list model.
module tb_sprite_oam_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] v_cnt = 8'd0;
  logic       size16 = 1'b0;
  logic       oam_rd;
  logic [7:0] oam_addr;
  logic [7:0] oam_di = 8'd0;
  logic       busy;
  logic       done;
  logic [3:0] sel_count;
  logic       overflow;
  logic [3:0] rd_index = 4'd0;
  logic       rd_valid;
  logic [7:0] rd_x;
  logic [5:0] rd_id;
  logic [3:0] rd_row;

  sprite_oam_scan dut (
    .clk(clk), .reset(reset), .start(start), .v_cnt(v_cnt), .size16(size16),
    .oam_rd(oam_rd), .oam_addr(oam_addr), .oam_di(oam_di),
    .busy(busy), .done(done), .sel_count(sel_count), .overflow(overflow),
    .rd_index(rd_index), .rd_valid(rd_valid), .rd_x(rd_x), .rd_id(rd_id), .rd_row(rd_row)
  );

  always #5 clk = ~clk;

  // OAM image: 4 bytes per entry, synchronous read with one cycle of latency.
  logic [7:0] oam [160];
  always @(posedge clk) oam_di <= oam[oam_addr];

  typedef struct packed {
    logic [3:0]      cnt;
    logic            ovf;
    logic [7:0]      busy_len;
    logic [9:0][7:0] x;
    logic [9:0][5:0] id;
    logic [9:0][3:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   scans_checked = 0;
  int   scans_issued = 0;
  int   busy_run = 0;

  function automatic exp_t model(input int line, input bit h16, input int blen);
    exp_t e;
    int   r;
    e = '0;
    e.busy_len = 8'(blen);
    for (int s = 0; s < 40; s++) begin
      r = (line + 16 - int'(oam[4*s])) & 255;
      if (r < (h16 ? 16 : 8)) begin
        if (e.cnt < 10) begin
          e.x[e.cnt]   = oam[4*s+1];
          e.id[e.cnt]  = 6'(s);
          e.row[e.cnt] = 4'(r);
          e.cnt        = e.cnt + 4'd1;
        end else begin
          e.ovf = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected list.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_run, int'(e.busy_len));
          check("sel_count", int'(sel_count), int'(e.cnt));
          check("overflow", int'(overflow), int'(e.ovf));
          for (int i = 0; i < 16; i++) begin
            rd_index = 4'(i);
            #1;
            if (i < int'(e.cnt))
              check($sformatf("slot%0d", i), int'({rd_valid, rd_x, rd_id, rd_row}),
                    int'({1'b1, e.x[i], e.id[i], e.row[i]}));
            else
              check($sformatf("slot%0d_empty", i), int'({rd_valid, rd_x, rd_id, rd_row}), 0);
          end
          scans_checked++;
        end
      end
      if (busy) busy_run++;
      else      busy_run = 0;
    end
  end

  task automatic pulse_start(input int line, input bit h16);
    @(negedge clk);
    v_cnt  = 8'(line);
    size16 = h16;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_checked();
    int k;
    k = 0;
    while (scans_checked < scans_issued && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (scans_checked < scans_issued) begin
      check("done_timeout", scans_checked, scans_issued);
      scans_checked = scans_issued;
    end
    @(negedge clk);
    check("idle_after_done", int'({busy, done}), 0);
  endtask

  task automatic run_scan(input int line, input bit h16);
    exp_q.push_back(model(line, h16, 81));
    scans_issued++;
    pulse_start(line, h16);
    wait_checked();
  endtask

  task automatic clear_oam();
    for (int a = 0; a < 160; a++) oam[a] = 8'd0;
  endtask

  task automatic random_oam(input int line);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) oam[4*s] = 8'($urandom);
      else                           oam[4*s] = 8'(line + 16 - int'($urandom_range(0, 20)));
      oam[4*s+1] = 8'($urandom);
      oam[4*s+2] = 8'($urandom);
      oam[4*s+3] = 8'($urandom);
    end
  endtask

  initial begin
    int line;
    clear_oam();
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_oam_rd", int'(oam_rd), 0);
    check("rst_oam_addr", int'(oam_addr), 0);
    check("rst_sel_count", int'(sel_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All Y=0 on line 5: nothing selected.
    run_scan(5, 1'b0);

    // Single sprite, then row 8 with and without 8x16 objects.
    oam[12] = 8'd20;
    oam[13] = 8'd50;
    run_scan(6, 1'b0);
    run_scan(12, 1'b0);
    run_scan(12, 1'b1);

    // Fifteen covering sprites: ten kept, overflow flagged.
    clear_oam();
    for (int s = 0; s < 15; s++) begin
      oam[4*s]   = 8'd16;
      oam[4*s+1] = 8'(s * 17 + 3);
    end
    run_scan(0, 1'b0);

    // Y wrap-around cases, including X outside the visible range.
    clear_oam();
    oam[156] = 8'd255;
    oam[157] = 8'd200;
    oam[1]   = 8'd0;
    run_scan(239, 1'b0);
    run_scan(240, 1'b0);
    run_scan(7, 1'b0);

    // Restart at c=40 with a different line; the second start owns the result.
    random_oam(60);
    pulse_start(30, 1'b0);
    repeat (40) @(posedge clk);
    exp_q.push_back(model(60, 1'b1, 122));
    scans_issued++;
    pulse_start(60, 1'b1);
    wait_checked();

    // Reset at c=20 aborts at once and never produces done.
    pulse_start(60, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_oam_rd", int'(oam_rd), 0);
    check("abort_oam_addr", int'(oam_addr), 0);
    check("abort_sel_count", int'(sel_count), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    check("abort_queue_empty", exp_q.size(), 0);

    for (int t = 0; t < 25; t++) begin
      line = int'($urandom_range(0, 255));
      random_oam(line);
      run_scan(line, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
